// File: rtl/alu_operand_loader_pkg.sv
// Shared definitions for alu_operand_loader: Alu opcodes, loader states and opcode class helpers.
package alu_operand_loader_pkg;

   localparam logic [2:0] PARITY   = 3'b000;
   localparam logic [2:0] POPCOUNT = 3'b001;
   localparam logic [2:0] ROTR     = 3'b010;
   localparam logic [2:0] ROTL     = 3'b011;

   typedef enum logic [1:0] {
      S_CMD    = 2'd0,
      S_LOAD_A = 2'd1,
      S_LOAD_B = 2'd2,
      S_ISSUE  = 2'd3
   } loader_state_e;

   // Reductions ignore B, so the short-B build never loads it for them.
   function automatic logic is_reduce_op(input logic [2:0] op);
      return (op == PARITY) || (op == POPCOUNT);
   endfunction

   // Rotates only need a shift amount, which fits in a single word.
   function automatic logic is_rot_op(input logic [2:0] op);
      return (op == ROTR) || (op == ROTL);
   endfunction

endpackage

// File: rtl/alu_operand_loader.sv
// Assembles a command word plus WORDS-wide A and B operands from a narrow stream and issues them to the Alu.
// Optional build macro ALU_LOADER_SHORT_B_EN shortens the B load for reduction and rotate opcodes.
module alu_operand_loader
   import alu_operand_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 512,
   parameter int WORD_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WORD_WIDTH-1:0] in_data,
   output logic [2:0]            opcode,
   output logic [DATA_WIDTH-1:0] A_out,
   output logic [DATA_WIDTH-1:0] B_out,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int WORDS = DATA_WIDTH / WORD_WIDTH;
   localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS - 1);

   loader_state_e    state;
   loader_state_e    next_state;
   logic [CNT_W-1:0] word_cnt;
   logic             xfer;
   logic             last_word;
   logic             skip_b;
   logic             rot_short;
   logic             b_last;

   assign xfer      = in_valid && in_ready;
   assign last_word = (word_cnt == LAST_CNT);

`ifdef ALU_LOADER_SHORT_B_EN
   assign skip_b    = is_reduce_op(opcode);
   assign rot_short = is_rot_op(opcode);
`else
   assign skip_b    = 1'b0;
   assign rot_short = 1'b0;
`endif

   assign b_last = last_word || rot_short;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_CMD;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode.
   always_comb begin
      next_state = state;
      case (state)
         S_CMD: begin
            if (xfer) next_state = S_LOAD_A;
            else      next_state = S_CMD;
         end
         S_LOAD_A: begin
            if (xfer && last_word) next_state = skip_b ? S_ISSUE : S_LOAD_B;
            else                   next_state = S_LOAD_A;
         end
         S_LOAD_B: begin
            if (xfer && b_last) next_state = S_ISSUE;
            else                next_state = S_LOAD_B;
         end
         S_ISSUE: begin
            if (out_ready) next_state = S_CMD;
            else           next_state = S_ISSUE;
         end
         default: next_state = S_CMD;
      endcase
   end

   // Handshake outputs decoded straight from the state register.
   always_comb begin
      in_ready  = 1'b1;
      out_valid = 1'b0;
      case (state)
         S_ISSUE: begin
            in_ready  = 1'b0;
            out_valid = 1'b1;
         end
         default: begin
            in_ready  = 1'b1;
            out_valid = 1'b0;
         end
      endcase
   end

   // Word counter, opcode and operand registers; they hold whenever no word transfers.
   always_ff @(posedge clk) begin
      if (rst) begin
         word_cnt <= '0;
         opcode   <= 3'b000;
         A_out    <= '0;
         B_out    <= '0;
      end else begin
         case (state)
            S_CMD: begin
               if (xfer) begin
                  opcode   <= in_data[2:0];
                  word_cnt <= '0;
               end
            end
            S_LOAD_A: begin
               if (xfer) begin
                  for (int w = 0; w < WORDS; w++) begin
                     if (word_cnt == CNT_W'(w)) A_out[w*WORD_WIDTH +: WORD_WIDTH] <= in_data;
                  end
                  if (last_word) begin
                     word_cnt <= '0;
                     if (skip_b) B_out <= '0;
                  end else begin
                     word_cnt <= word_cnt + CNT_W'(1);
                  end
               end
            end
            S_LOAD_B: begin
               if (xfer) begin
                  if (rot_short) begin
                     B_out    <= DATA_WIDTH'(in_data);
                     word_cnt <= '0;
                  end else begin
                     for (int w = 0; w < WORDS; w++) begin
                        if (word_cnt == CNT_W'(w)) B_out[w*WORD_WIDTH +: WORD_WIDTH] <= in_data;
                     end
                     if (last_word) word_cnt <= '0;
                     else           word_cnt <= word_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader: directed and randomized operations against a word-list model.
module tb_alu_operand_loader;
   import alu_operand_loader_pkg::*;

   localparam int DW    = 512;
   localparam int WW    = 32;
   localparam int WORDS = DW / WW;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [WW-1:0] in_data;
   logic [2:0]    opcode;
   logic [DW-1:0] A_out;
   logic [DW-1:0] B_out;
   logic          out_valid;
   logic          out_ready;

   int total = 0;
   int bad   = 0;

   alu_operand_loader #(.DATA_WIDTH(DW), .WORD_WIDTH(WW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .opcode(opcode), .A_out(A_out), .B_out(B_out), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; all driving and sampling happens 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [WW-1:0] w, input int gap);
      int waited;
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0;
         in_data  = WW'($urandom);
         tick();
      end
      in_valid = 1'b1;
      in_data  = w;
      waited   = 0;
      while (!in_ready && waited < 50) begin
         tick();
         waited++;
      end
      if (!in_ready) chk("in_ready_timeout", DW'(in_ready), DW'(1'b1));
      tick();
      in_valid = 1'b0;
      in_data  = WW'($urandom);
   endtask

   // Model: number of B words the loader expects for an opcode.
   function automatic int b_words(input logic [2:0] op);
`ifdef ALU_LOADER_SHORT_B_EN
      if (op == PARITY || op == POPCOUNT) return 0;
      if (op == ROTR || op == ROTL)       return 1;
`endif
      return WORDS;
   endfunction

   task automatic run_op(input logic [2:0] op, input logic [WW-1:0] aw[WORDS], input logic [WW-1:0] bw[WORDS],
                         input int max_gap, input int hold);
      logic [DW-1:0] exp_a;
      logic [DW-1:0] exp_b;
      int nb;
      int n_total;
      int sent;
      nb      = b_words(op);
      n_total = 1 + WORDS + nb;
      exp_a   = '0;
      exp_b   = '0;
      for (int i = 0; i < WORDS; i++) exp_a = exp_a | (DW'(aw[i]) << (i * WW));
      for (int i = 0; i < nb; i++)    exp_b = exp_b | (DW'(bw[i]) << (i * WW));
      sent = 0;
      send_word({29'($urandom), op}, $urandom_range(0, max_gap));
      sent++;
      for (int i = 0; i < WORDS + nb; i++) begin
         if (sent == n_total - 1) chk("no_early_valid", DW'(out_valid), DW'(1'b0));
         if (i < WORDS) send_word(aw[i], $urandom_range(0, max_gap));
         else           send_word(bw[i - WORDS], $urandom_range(0, max_gap));
         sent++;
      end
      chk("issue_valid", DW'(out_valid), DW'(1'b1));
      chk("issue_in_ready", DW'(in_ready), DW'(1'b0));
      chk("issue_opcode", DW'(opcode), DW'(op));
      chk("issue_A", A_out, exp_a);
      chk("issue_B", B_out, exp_b);
      out_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         in_valid = 1'b1;
         in_data  = WW'($urandom);
         tick();
         chk("hold_valid", DW'(out_valid), DW'(1'b1));
         chk("hold_in_ready", DW'(in_ready), DW'(1'b0));
         chk("hold_A", A_out, exp_a);
         chk("hold_B", B_out, exp_b);
         chk("hold_opcode", DW'(opcode), DW'(op));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("after_issue_valid", DW'(out_valid), DW'(1'b0));
      chk("after_issue_in_ready", DW'(in_ready), DW'(1'b1));
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_opcode"}, DW'(opcode), DW'(3'b000));
      chk({tag, "_A"}, A_out, '0);
      chk({tag, "_B"}, B_out, '0);
      chk({tag, "_out_valid"}, DW'(out_valid), DW'(1'b0));
      chk({tag, "_in_ready"}, DW'(in_ready), DW'(1'b1));
   endtask

   initial begin
      logic [WW-1:0] aw[WORDS];
      logic [WW-1:0] bw[WORDS];
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;

      // Reset held for two cycles.
      tick();
      tick();
      rst = 1'b0;
      check_reset_state("reset");

      // POPCOUNT with A = 0xAD, back-to-back input.
      for (int i = 0; i < WORDS; i++) begin
         aw[i] = '0;
         bw[i] = WW'($urandom);
      end
      aw[0] = 32'h0000_00AD;
      run_op(POPCOUNT, aw, bw, 0, 0);

      // Random ops with input gaps and five cycles of out_ready backpressure.
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < WORDS; i++) begin
            aw[i] = WW'($urandom);
            bw[i] = WW'($urandom);
         end
         run_op(3'(k + 2), aw, bw, 3, (k == 0) ? 5 : $urandom_range(0, 3));
      end

      // Reset after A word 7 of a partial load.
      send_word(32'h0000_0002, 0);
      for (int i = 0; i < 8; i++) send_word(WW'($urandom) | 32'h1, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_state("midload_reset");
      for (int i = 0; i < WORDS; i++) begin
         aw[i] = WW'($urandom);
         bw[i] = WW'($urandom);
      end
      run_op(ROTL, aw, bw, 1, 1);

      // Reset while an operation is waiting to issue.
      for (int i = 0; i < WORDS; i++) begin
         aw[i] = WW'($urandom);
         bw[i] = WW'($urandom);
      end
      aw[0] = 32'h0000_00AC;
      bw[0] = 32'h0000_0003;
      send_word(32'h0000_0001, 0);
      for (int i = 0; i < WORDS + b_words(3'b001); i++) send_word((i < WORDS) ? aw[i] : bw[i - WORDS], 0);
      chk("pre_reset_issue_valid", DW'(out_valid), DW'(1'b1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_reset_state("issue_reset");

      // Short-B boundary opcodes (full B loads unless the short-B build is selected).
      for (int i = 0; i < WORDS; i++) aw[i] = '0;
      aw[0] = 32'h0000_00AD;
      bw[0] = 32'h0000_0003;
      run_op(ROTR, aw, bw, 0, 2);
      aw[0] = 32'h0000_00AC;
      run_op(PARITY, aw, bw, 2, 1);
      run_op(3'b111, aw, bw, 1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
